// File: rtl/sprite_mem_arbiter.sv
// Three-way round-robin arbiter for a shared sprite memory with a fixed 2-cycle
// grant-to-data return pipeline and a per-scanline stall counter.
module sprite_mem_arbiter #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              line_start,
  output logic [2:0]        gnt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rd_valid,
  output logic [1:0]        rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        stall_cnt
);

  logic [2:0]        r_gnt;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_last;
  logic              r_p1_valid;
  logic [1:0]        r_p1_id;
  logic              r_rd_valid;
  logic [1:0]        r_rd_id;
  logic [DATA_W-1:0] r_rd_data;
  logic [7:0]        r_stall;

  logic [1:0]        w_last_eff;
  logic [1:0]        w_start;
  logic [2:0]        w_elig;
  logic              w_win_vld;
  logic [1:0]        w_win_id;
  logic [ADDR_W-1:0] w_addr_sel;
  logic              w_stall;

  function automatic logic [1:0] rr_idx(input logic [1:0] start, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, start} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    w_win_vld  = 1'b0;
    w_win_id   = 2'd0;
    // line_start re-seeds the pointer for this very cycle's search
    w_last_eff = line_start ? 2'd1 : r_last;
    w_start    = (w_last_eff == 2'd2) ? 2'd0 : w_last_eff + 2'd1;
    // the requester shown a grant this cycle must not win again on the same sample
    w_elig     = req & ~r_gnt;
    for (int k = 2; k >= 0; k--) begin
      if (w_elig[rr_idx(w_start, 2'(k))]) begin
        w_win_vld = 1'b1;
        w_win_id  = rr_idx(w_start, 2'(k));
      end
    end
    unique case (w_win_id)
      2'd0:    w_addr_sel = addr0;
      2'd1:    w_addr_sel = addr1;
      default: w_addr_sel = addr2;
    endcase
    w_stall = |(req & ~r_gnt);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_gnt      <= 3'b000;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_last     <= 2'd2;
      r_p1_valid <= 1'b0;
      r_p1_id    <= 2'd0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 2'd0;
      r_rd_data  <= '0;
      r_stall    <= 8'd0;
    end else begin
      r_gnt    <= w_win_vld ? (3'b001 << w_win_id) : 3'b000;
      r_mem_rd <= w_win_vld;
      if (w_win_vld) begin
        r_mem_addr <= w_addr_sel;
        r_last     <= w_win_id;
      end else begin
        r_last     <= w_last_eff;
      end
      // r_last holds the winner of the grant currently on mem_rd
      r_p1_valid <= r_mem_rd;
      r_p1_id    <= r_last;
      r_rd_valid <= r_p1_valid;
      if (r_p1_valid) begin
        r_rd_id   <= r_p1_id;
        r_rd_data <= mem_data;
      end
      if (line_start) begin
        r_stall <= 8'd0;
      end else if (w_stall && (r_stall != 8'hFF)) begin
        r_stall <= r_stall + 8'd1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign rd_valid  = r_rd_valid;
  assign rd_id     = r_rd_id;
  assign rd_data   = r_rd_data;
  assign stall_cnt = r_stall;

endmodule
